// File: rtl/winograd_in_tf_pkg.sv
// Shared definitions for the Winograd F(2,3) input/filter transform block.
// Holds the default data width and FIFO depth, the frame geometry (six
// slots per frame, three of them carrying rows) and the slot/frame state
// types used by the top level.
package winograd_in_tf_pkg;

  localparam int unsigned WINO_DW      = 32;
  localparam int unsigned WINO_DEPTH   = 4;
  localparam int unsigned FRAME_LEN    = 6;
  localparam int unsigned ACTIVE_SLOTS = 3;

  typedef enum logic [2:0] {
    SLOT_0 = 3'd0,
    SLOT_1 = 3'd1,
    SLOT_2 = 3'd2,
    SLOT_3 = 3'd3,
    SLOT_4 = 3'd4,
    SLOT_5 = 3'd5
  } slot_e;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_ACTIVE
  } frame_e;

  // Free-running slot sequence 0..FRAME_LEN-1 with wrap.
  function automatic slot_e next_slot(input slot_e s);
    if (32'(s) >= FRAME_LEN - 1) return SLOT_0;
    return slot_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/wino_row_fifo.sv
// Row FIFO for the Winograd input transform.
// Stores whole tile rows (W bits each) in strict first-in first-out order.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (empties the FIFO)
//   push_i        write wdata_i at the tail (caller guarantees not full)
//   wdata_i       row to store
//   pop_i         drop the head row (caller guarantees not empty)
//   rdata_o       current head row (combinational)
//   count_o       number of rows held, 0..DEPTH
module wino_row_fifo #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 wdata_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/winograd_in_tf.sv
// Winograd F(2,3) input and filter transform front end.
// Input tile rows are buffered in a row FIFO. A free-running six-slot frame
// counter schedules output: when three rows are available at slot 5, the
// next frame presents the transformed rows in slots 0..2; otherwise the
// frame is idle. Filter taps are transformed into a shadow register on
// w_load and published only at the edge entering slot 0.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      input row handshake
//   d0..d3                   input row (signed)
//   w_load, g0..g2           filter load request and 3 taps (signed)
//   x1..x4                   transformed row, registered
//   w1..w4                   transformed weights, registered
//   out_valid                high while x1..x4 carry a row (slots 0..2)
//   frame_start              high in slot 0 (low during reset)
module winograd_in_tf
  import winograd_in_tf_pkg::*;
#(
  parameter int unsigned DW    = WINO_DW,
  parameter int unsigned DEPTH = WINO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic          w_load,
  input  logic [DW-1:0] g0,
  input  logic [DW-1:0] g1,
  input  logic [DW-1:0] g2,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3,
  output logic [DW-1:0] x4,
  output logic [DW-1:0] w1,
  output logic [DW-1:0] w2,
  output logic [DW-1:0] w3,
  output logic [DW-1:0] w4,
  output logic          out_valid,
  output logic          frame_start
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = 4 * DW;

  slot_e  slot_q,  slot_d;
  frame_e frame_q, frame_d;

  logic [CW-1:0] fifo_count;
  logic [RW-1:0] fifo_head;
  logic          fifo_push;
  logic          fifo_pop;
  logic          have_frame;

  logic [DW-1:0] h0, h1, h2, h3;

  logic [3:0][DW-1:0] x_q,  x_d;
  logic [3:0][DW-1:0] w_q,  w_d;
  logic [3:0][DW-1:0] sh_q, sh_d;
  logic [3:0][DW-1:0] w_new;
  logic               out_valid_q, out_valid_d;

  logic signed [DW+1:0] g0_x, g1_x, g2_x;
  logic signed [DW+1:0] sum_p, sum_m;

  // Handshake and frame flags are forced low while reset is held.
  assign in_ready    = !rst && (fifo_count < CW'(DEPTH));
  assign fifo_push   = in_valid && in_ready;
  assign frame_start = !rst && (slot_q == SLOT_0);
  assign have_frame  = (fifo_count >= CW'(ACTIVE_SLOTS));

  wino_row_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i ({d3, d2, d1, d0}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );

  assign h0 = fifo_head[0*DW +: DW];
  assign h1 = fifo_head[1*DW +: DW];
  assign h2 = fifo_head[2*DW +: DW];
  assign h3 = fifo_head[3*DW +: DW];

  // Frame scheduling. The decision in slot 5 uses the pre-edge count, and
  // the first row is popped on that same edge so it is visible in slot 0.
  // Once three rows were seen, the pops at the end of slots 0 and 1 cannot
  // underflow because nothing else removes rows in between.
  always_comb begin
    slot_d   = next_slot(slot_q);
    frame_d  = frame_q;
    fifo_pop = 1'b0;
    if (slot_q == SLOT_5) begin
      frame_d  = have_frame ? FRAME_ACTIVE : FRAME_IDLE;
      fifo_pop = have_frame;
    end else if (frame_q == FRAME_ACTIVE && 32'(slot_q) < ACTIVE_SLOTS - 1) begin
      fifo_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= SLOT_0;
      frame_q <= FRAME_IDLE;
    end else begin
      slot_q  <= slot_d;
      frame_q <= frame_d;
    end
  end

  // Input transform B^T d, registered only on pop; zero otherwise.
  always_comb begin
    x_d         = '0;
    out_valid_d = fifo_pop;
    if (fifo_pop) begin
      x_d[0] = h0 - h2;
      x_d[1] = h1 + h2;
      x_d[2] = h2 - h1;
      x_d[3] = h1 - h3;
    end
  end

  // Filter transform G g. Sums are two bits wider than the taps so that
  // the halving is exact before truncation back to DW.
  assign g0_x  = {{2{g0[DW-1]}}, g0};
  assign g1_x  = {{2{g1[DW-1]}}, g1};
  assign g2_x  = {{2{g2[DW-1]}}, g2};
  assign sum_p = g0_x + g1_x + g2_x;
  assign sum_m = g0_x - g1_x + g2_x;

  always_comb begin
    w_new[0] = g0;
    w_new[1] = DW'(sum_p >>> 1);
    w_new[2] = DW'(sum_m >>> 1);
    w_new[3] = g2;
    sh_d     = w_load ? w_new : sh_q;
    // Publishing from sh_d lets a load in slot 5 reach the very next frame.
    w_d      = (slot_q == SLOT_5) ? sh_d : w_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      w_q         <= '0;
      sh_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      w_q         <= w_d;
      sh_q        <= sh_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign x1        = x_q[0];
  assign x2        = x_q[1];
  assign x3        = x_q[2];
  assign x4        = x_q[3];
  assign w1        = w_q[0];
  assign w2        = w_q[1];
  assign w3        = w_q[2];
  assign w4        = w_q[3];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_winograd_in_tf.sv
module tb_winograd_in_tf;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef logic [DW-1:0] word_t;
  typedef struct {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
  } row4_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  logic  in_ready;
  word_t d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic  w_load = 1'b0;
  word_t g0 = '0, g1 = '0, g2 = '0;
  word_t x1, x2, x3, x4, w1, w2, w3, w4;
  logic  out_valid, frame_start;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  winograd_in_tf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .w_load(w_load), .g0(g0), .g1(g1), .g2(g2),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .out_valid(out_valid), .frame_start(frame_start)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  row4_t mq[$];      // rows accepted but not yet emitted
  row4_t exp_q[$];   // scoreboard: transformed rows awaiting the monitor
  int    mslot = 0;  // frame position of the current cycle
  bit    mact  = 0;  // current frame carries rows
  row4_t wsh, wexp;
  int    m_sz;
  bit    m_pop, m_acc;
  row4_t m_row;

  function automatic row4_t xform(input row4_t r);
    row4_t o;
    o.a = r.a - r.c;
    o.b = r.b + r.c;
    o.c = r.c - r.b;
    o.d = r.b - r.d;
    return o;
  endfunction

  function automatic row4_t wform(input word_t a, input word_t b, input word_t c);
    row4_t  o;
    longint sp, sm;
    sp  = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c));
    sm  = longint'($signed(a)) - longint'($signed(b)) + longint'($signed(c));
    o.a = a;
    o.b = word_t'(sp >>> 1);
    o.c = word_t'(sm >>> 1);
    o.d = c;
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      mslot = 0;
      mact  = 0;
      wsh   = '{default: '0};
      wexp  = '{default: '0};
    end else begin
      m_sz  = mq.size();
      m_acc = in_valid && (m_sz < DEPTH);
      m_pop = (mslot == 5 && m_sz >= 3) || (mslot < 2 && mact);
      if (mslot == 5) mact = (m_sz >= 3);
      if (m_pop) exp_q.push_back(xform(mq.pop_front()));
      if (m_acc) begin
        m_row = '{d0, d1, d2, d3};
        mq.push_back(m_row);
      end
      if (w_load) wsh = wform(g0, g1, g2);
      if (mslot == 5) wexp = wsh;
      mslot = (mslot + 1) % 6;
    end
  end

  // ---------------- monitor ----------------
  row4_t mon_r;
  always @(negedge clk) begin
    chk("in_ready", in_ready, (!rst && mq.size() < DEPTH));
    chk("frame_start", frame_start, (!rst && mslot == 0));
    chk("w1", w1, wexp.a);
    chk("w2", w2, wexp.b);
    chk("w3", w3, wexp.c);
    chk("w4", w4, wexp.d);
    if (out_valid) begin
      chk("valid_has_expect", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_r = exp_q.pop_front();
        chk("x1", x1, mon_r.a);
        chk("x2", x2, mon_r.b);
        chk("x3", x3, mon_r.c);
        chk("x4", x4, mon_r.d);
      end
    end else begin
      chk("x_zero", {x1, x2}, '0);
      chk("x_zero_hi", {x3, x4}, '0);
    end
    chk("row_missing", exp_q.size(), 0);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_row(input word_t a, input word_t b, input word_t c, input word_t d);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    d0 = a; d1 = b; d2 = c; d3 = d;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask

  task automatic wait_slot(input int s);
    bit hit;
    hit = (mslot == s);
    for (int i = 0; i < 12 && !hit; i++) begin
      step();
      hit = (mslot == s);
    end
    chk("wait_slot", hit, 1);
  endtask

  task automatic wait_valid(output bit got);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
  endtask

  task automatic expect_row(input string nm, input word_t a, input word_t b,
                            input word_t c, input word_t d);
    bit got;
    wait_valid(got);
    chk({nm, "_valid"}, got, 1);
    if (got) begin
      chk({nm, "_x1"}, x1, a);
      chk({nm, "_x2"}, x2, b);
      chk({nm, "_x3"}, x3, c);
      chk({nm, "_x4"}, x4, d);
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("release_frame_start", frame_start, 1);
    chk("release_in_ready", in_ready, 1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    got, acc, saw_low;
    word_t mx;
    mx = 32'h7FFF_FFFF;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x1", x1, 0);
    chk("rst_w2", w2, 0);
    rst = 1'b0;
    #1;
    chk("first_frame_start", frame_start, 1);
    chk("first_in_ready", in_ready, 1);
    #1;

    // Three rows before slot 5 -> emitted in slots 0..2 of next frame.
    push_row(1, 2, 3, 4);
    push_row(5, 6, 7, 8);
    push_row(9, 10, 11, 12);
    expect_row("basic_r0", -2, 5, 1, -2);
    expect_row("basic_r1", -2, 13, 1, -2);
    expect_row("basic_r2", -2, 21, 1, -2);

    // Two rows only: idle frame; a third row releases all three in order.
    push_row(10, 20, 30, 40);
    push_row(1, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_valid", out_valid, 0);
    end
    push_row(7, 3, 5, 2);
    expect_row("late_r0", -20, 50, 10, -20);
    expect_row("late_r1", 0, 2, 0, 0);
    expect_row("late_r2", 2, 8, 2, 1);

    // Continuous valid for 20 cycles; data advances only on acceptance.
    step();
    saw_low = 0;
    in_valid = 1'b1;
    d0 = $urandom(); d1 = $urandom(); d2 = $urandom(); d3 = $urandom();
    for (int i = 0; i < 20; i++) begin
      acc = in_ready;
      if (!in_ready) saw_low = 1;
      step();
      if (acc) begin
        d0 = $urandom(); d1 = $urandom(); d2 = $urandom(); d3 = $urandom();
      end
    end
    in_valid = 1'b0;
    chk("stream_backpressure", saw_low, 1);
    repeat (24) step();

    do_reset();

    // Weight load in slot 3, published at next slot 0.
    wait_slot(3);
    w_load = 1'b1; g0 = 2; g1 = 4; g2 = 6;
    step();
    w_load = 1'b0;
    wait_slot(0);
    chk("wload_w1", w1, 2);
    chk("wload_w2", w2, 6);
    chk("wload_w3", w3, 2);
    chk("wload_w4", w4, 6);
    wait_slot(1);
    w_load = 1'b1; g0 = 1; g1 = 1; g2 = 1;
    step();
    w_load = 1'b0;
    chk("wload_hold_w2", w2, 6);
    wait_slot(0);
    chk("wload2_w2", w2, 1);
    chk("wload2_w3", w3, 0);

    // Wide-sum truncation and wrapping adds.
    w_load = 1'b1; g0 = mx; g1 = mx; g2 = mx;
    step();
    w_load = 1'b0;
    wait_slot(0);
    chk("wide_w2", w2, 32'hBFFF_FFFE);
    chk("wide_w3", w3, 32'h3FFF_FFFF);
    push_row(0, mx, mx, 0);
    push_row(0, mx, mx, 0);
    push_row(0, mx, mx, 0);
    for (int i = 0; i < 3; i++)
      expect_row("wrap", 32'h8000_0001, 32'hFFFF_FFFE, 0, mx);

    // Reset in slot 1 of an active frame.
    step();
    push_row($urandom(), $urandom(), $urandom(), $urandom());
    push_row($urandom(), $urandom(), $urandom(), $urandom());
    push_row($urandom(), $urandom(), $urandom(), $urandom());
    push_row($urandom(), $urandom(), $urandom(), $urandom());
    wait_valid(got);
    chk("midrst_valid_seen", got, 1);
    step();
    chk("midrst_slot1_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_x2", x2, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_frame_start", frame_start, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("midrst_release_fs", frame_start, 1);
    chk("midrst_release_rdy", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_flushed", out_valid, 0);
    end

    // Randomized traffic with occasional weight loads.
    step();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      d0 = $urandom(); d1 = $urandom(); d2 = $urandom(); d3 = $urandom();
      w_load = ($urandom_range(0, 9) == 0);
      g0 = $urandom(); g1 = $urandom(); g2 = $urandom();
      step();
    end
    in_valid = 1'b0;
    w_load = 1'b0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/winograd_in_tf.md
WINOGRAD_IN_TF -- requirements
Module: winograd_in_tf

Interface
REQ-001 SHALL have parameter DW, default 32: data width of every sample and weight, signed two's complement.
REQ-002 SHALL have parameter DEPTH, default 4: input row FIFO depth, minimum 3.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1  valid/ready handshake for input rows.
REQ-006 SHALL have ports d0, d1, d2, d3  input  DW each  one input tile row, signed.
REQ-007 SHALL have ports w_load input 1 and g0, g1, g2 input DW each  3-tap filter load request.
REQ-008 SHALL have ports x1, x2, x3, x4  output  DW each  transformed row to the downstream multiply stage, registered.
REQ-009 SHALL have ports w1, w2, w3, w4  output  DW each  transformed weights, registered.
REQ-010 SHALL have ports out_valid output 1 and frame_start output 1  row-valid and frame-slot-0 flags.

Function
REQ-011 SHALL run a free-running slot counter 0..5, incrementing every cycle and wrapping 5->0; frame_start = (slot == 0).
REQ-012 SHALL assert in_ready when FIFO count < DEPTH; a row is pushed on any cycle with in_valid && in_ready.
REQ-013 SHALL decide in slot 5: if FIFO count (excluding any same-cycle push) >= 3, the next frame is active; otherwise it is idle.
REQ-014 For an active frame, SHALL pop one row at each of the edges ending slots 5, 0 and 1, so x1..x4 hold rows r0, r1, r2 during slots 0, 1, 2 respectively.
REQ-015 SHALL compute on pop: x1 = d0 - d2, x2 = d1 + d2, x3 = d2 - d1, x4 = d1 - d3, each wrapped modulo 2^DW.
REQ-016 SHALL hold x1..x4 at zero and out_valid low in slots 3, 4, 5 and throughout idle frames; out_valid is high exactly in slots 0..2 of active frames.
REQ-017 SHALL allow simultaneous push and pop in one cycle; count is unchanged and in_ready is based on the pre-edge count.
REQ-018 SHALL never drop or duplicate a row; FIFO order is strict first-in first-out.
REQ-019 On w_load, SHALL capture into a shadow register: w1 = g0, w2 = (g0+g1+g2)>>>1, w3 = (g0-g1+g2)>>>1, w4 = g2. Sums SHALL be formed at DW+2 bits, arithmetically shifted, and truncated to DW.
REQ-020 SHALL copy shadow to w1..w4 only at the edge entering slot 0, so weights never change mid-frame; a w_load in slot 5 takes effect in the immediately following frame.
REQ-021 Back-to-back w_load SHALL keep the last value captured before the slot-0 edge.

Reset
REQ-022 While rst is high: slot = 0, FIFO empty, in_ready = 0, x1..x4 = 0, w1..w4 = 0, shadow = 0, out_valid = 0, frame_start = 0.
REQ-023 After rst deasserts, slot 0 is the first cycle; in_ready rises in that cycle. Reset mid-frame SHALL discard all buffered rows and the partial frame.

Structure
REQ-024 DW, DEPTH, frame length 6 and active-slot count 3 SHALL live in the shared project package.
REQ-025 The row FIFO SHALL be a separate sub-module, wino_row_fifo: parameterised DW*4 width, depth DEPTH, with push/pop/count.
REQ-026 The transform arithmetic SHALL be combinational inside winograd_in_tf; there are no multipliers.

Verification
REQ-027 Push rows (1,2,3,4), (5,6,7,8), (9,10,11,12) before slot 5. The response is out_valid in slots 0..2, with x = (-2,5,1,-2), (-2,13,1,-2), (-2,21,1,-2).
REQ-028 Push only 2 rows, then wait. The next frame is idle (x = 0, out_valid = 0). After a third row arrives, the following frame emits all three rows in order.
REQ-029 Hold in_valid high with no stall for 20 cycles. in_ready drops at count 4, and the output sequence equals the input sequence with no loss.
REQ-030 Load g = (2,4,6) in slot 3. The response is w = (2,6,2,6) from the next slot 0. A second w_load in slot 1 of that frame does not change w until the following slot 0.
REQ-031 Load g = (0x7FFFFFFF, 0x7FFFFFFF, 0x7FFFFFFF). The response is w2 = 0xBFFFFFFE, showing wide-sum truncation. Set d1 = d2 = 0x7FFFFFFF. The response is x2 = 0xFFFFFFFE (wrap).
REQ-032 Assert rst in slot 1 of an active frame. Outputs go to zero immediately, the FIFO is empty, and after release frame_start appears in the first cycle.
